// File: rtl/register_file_32x32_pkg.sv
// Shared register-file constants and ALU command encoding used across the CPU datapath.
package register_file_32x32_pkg;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         REG_WIDTH     = 32;
  localparam int         REG_ADDR_BITS = 5;
  localparam int         REG_DEPTH     = 1 << REG_ADDR_BITS;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_OR   = 3'd7
  } alu_cmd_e;

endpackage

// File: rtl/register_file_32x32_register32.sv
// Plain D register with write enable and asynchronous active-high clear.
module register32 #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             wrenable,
  input  logic             clk,
  input  logic             reset
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         q <= '0;
    else if (wrenable) q <= d;
  end

endmodule

// File: rtl/register_file_32x32.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write port, $0 hardwired to zero.
module register_file_32x32
  import register_file_32x32_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int DEPTH  = REG_DEPTH,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_ADDR_BITS-1:0] read_addr1,
  input  logic [REG_ADDR_BITS-1:0] read_addr2,
  output logic [WIDTH-1:0]         read_data1,
  output logic [WIDTH-1:0]         read_data2,
  input  logic [REG_ADDR_BITS-1:0] write_addr,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     write_enable
);

  logic [DEPTH-1:0] dec_onehot;
  logic [DEPTH-1:0] wr_en_vec;
  logic [WIDTH-1:0] regs [DEPTH];
  logic             byp1;
  logic             byp2;

  // Decoder output 0 is forced low so $0 can never be selected for writing.
  always_comb begin
    dec_onehot             = '0;
    dec_onehot[write_addr] = 1'b1;
    dec_onehot[REG_ZERO]   = 1'b0;
  end

  assign wr_en_vec = dec_onehot & {DEPTH{write_enable}};

  assign regs[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    register32 #(.WIDTH(WIDTH)) u_reg (
      .q        (regs[i]),
      .d        (write_data),
      .wrenable (wr_en_vec[i]),
      .clk      (clk),
      .reset    (reset)
    );
  end

  // Forwarding is suppressed during reset so reads stay 0 while registers are held clear.
  assign byp1 = (BYPASS != 0) && write_enable && !reset && (write_addr == read_addr1);
  assign byp2 = (BYPASS != 0) && write_enable && !reset && (write_addr == read_addr2);

  assign read_data1 = (read_addr1 == REG_ZERO) ? '0 :
                      byp1                     ? write_data : regs[read_addr1];
  assign read_data2 = (read_addr2 == REG_ZERO) ? '0 :
                      byp2                     ? write_data : regs[read_addr2];

endmodule

// File: tb/tb_register_file_32x32.sv
// Scoreboard bench: one forwarding and one non-forwarding instance share stimulus, checked against a reference model.
module tb_register_file_32x32;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_addr1, read_addr2, write_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

  register_file_32x32 #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1_b), .read_data2(rd2_b),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable)
  );

  register_file_32x32 #(.BYPASS(0)) u_nob (
    .clk(clk), .reset(reset),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1_n), .read_data2(rd2_n),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          port;   // 0 rd1_b, 1 rd2_b, 2 rd1_n, 3 rd2_n, 4 alu result, 5 alu overflow
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_sub(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

  function automatic logic alu_sub_ovf(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = a - b;
    return (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

  function automatic logic [31:0] observe(input int port);
    case (port)
      0: return rd1_b;
      1: return rd2_b;
      2: return rd1_n;
      3: return rd2_n;
      4: return alu_sub(rd1_b, rd2_b);
      5: return {31'd0, alu_sub_ovf(rd1_b, rd2_b)};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int port, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Expected read on a port given the model, with or without forwarding.
  function automatic logic [31:0] model_read(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 32'h0;
    if (byp && write_enable && !reset && write_addr == ra) return write_data;
    return mdl[ra];
  endfunction

  task automatic push_all(input string tag);
    push({tag, ".r1b"}, 0, model_read(read_addr1, 1'b1));
    push({tag, ".r2b"}, 1, model_read(read_addr2, 1'b1));
    push({tag, ".r1n"}, 2, model_read(read_addr1, 1'b0));
    push({tag, ".r2n"}, 3, model_read(read_addr2, 1'b0));
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.port), e.exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    write_enable = 1'b1;
    write_addr   = a;
    write_data   = d;
    @(posedge clk); #1;
    write_enable = 1'b0;
    if (a != 5'd0) mdl[a] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    reset = 1'b1; write_enable = 1'b0; write_addr = 5'd0; write_data = 32'h0;
    read_addr1 = 5'd5; read_addr2 = 5'd31;

    // Reset state, then out of reset
    #1;
    push_all("in_reset"); drain();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    push_all("post_reset"); drain();

    // Plain write then read; neighbour untouched
    write_reg(5'd7, 32'hDEAD_BEEF);
    read_addr1 = 5'd7; read_addr2 = 5'd8;
    #1;
    push_all("wr7"); drain();

    // Writes to $0 are discarded
    read_addr1 = 5'd0;
    write_enable = 1'b1; write_addr = 5'd0; write_data = 32'hFFFF_FFFF;
    #1;
    push_all("r0_pre"); drain();
    @(posedge clk); #1;
    push_all("r0_post"); drain();
    write_enable = 1'b0;

    // Same-cycle write/read: forwarding vs stored value
    write_reg(5'd3, 32'h0000_0001);
    read_addr2 = 5'd3;
    write_enable = 1'b1; write_addr = 5'd3; write_data = 32'h5A5A_5A5A;
    #1;
    push("byp_pre.r2b", 1, 32'h5A5A_5A5A);
    push("byp_pre.r2n", 3, 32'h0000_0001);
    drain();
    @(posedge clk); #1;
    write_enable = 1'b0;
    mdl[3] = 32'h5A5A_5A5A;
    push("byp_post.r2b", 1, 32'h5A5A_5A5A);
    push("byp_post.r2n", 3, 32'h5A5A_5A5A);
    drain();

    // Operands through a SUB
    write_reg(5'd1, 32'h0000_0005);
    write_reg(5'd2, 32'hFFFF_FFFE);
    read_addr1 = 5'd1; read_addr2 = 5'd2;
    #1;
    push("alu_sub.res", 4, 32'h0000_0007);
    push("alu_sub.ovf", 5, 32'h0000_0000);
    drain();

    // Asynchronous reset mid-cycle, write during reset lost
    write_reg(5'd9, 32'h1234_5678);
    read_addr1 = 5'd9;
    #1;
    push("r9_load.r1b", 0, 32'h1234_5678);
    push("r9_load.r1n", 2, 32'h1234_5678);
    drain();
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    push("async_rst.r1b", 0, 32'h0);
    push("async_rst.r1n", 2, 32'h0);
    drain();
    write_enable = 1'b1; write_addr = 5'd9; write_data = 32'hCAFE_F00D;
    #1;
    push("rst_wr_pre.r1b", 0, 32'h0);
    drain();
    @(posedge clk); #1;
    push("rst_wr_edge.r1b", 0, 32'h0);
    push("rst_wr_edge.r1n", 2, 32'h0);
    drain();
    write_enable = 1'b0;
    reset = 1'b0;
    #1;
    push_all("after_rst"); drain();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      write_enable = ($urandom_range(0, 3) != 0);
      write_addr   = 5'($urandom_range(0, 31));
      write_data   = $urandom;
      read_addr1   = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
      read_addr2   = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
      #2;
      push_all("rand");
      @(negedge clk);
      drain();
      if (write_enable && write_addr != 5'd0) mdl[write_addr] = write_data;
    end
    @(posedge clk); #1;
    write_enable = 1'b0;
    for (int a = 0; a < 32; a++) begin
      read_addr1 = 5'(a);
      read_addr2 = 5'(31 - a);
      #1;
      push_all("sweep"); drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
